i2s_tx_axis: RTL and testbench

//  AXI4-Stream slave to I2S master transmitter: one 32-bit word = one stereo frame (L=[31:16], R=[15:0]).

---
 rtl/i2s_tx_axis.sv | 204 ++++++++++++++++++++
 tb/tb_i2s_tx_axis.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_axis.sv
//
// i2s_tx_axis
// -----------
// AXI4-Stream slave to I2S master transmitter. Each accepted 32-bit stream
// word is one stereo frame: left sample in [31:16], right sample in [15:0],
// both 16-bit two's complement. The block derives the I2S bit clock and word
// select from an externally supplied audio master clock. It then shifts each
// sample out MSB-first with the standard I2S one-bit delay after every word
// select change.
//
// All logic runs on s00_axis_aclk. mclk is only sampled and is never used
// as a clock. Its high and low phases must each last at least 2 aclk cycles
// so that the synchronizer sees every edge.
//
// Ports
//   s00_axis_aclk    in   1   clock for all logic
//   s00_axis_areset  in   1   synchronous, active-high reset
//   mclk             in   1   audio master clock (sampled)
//   bclk             out  1   I2S bit clock, mclk/4, 50% duty
//   lrclk            out  1   word select, 0 = left, 1 = right, 64 bclk period
//   sdata            out  1   serial data, changes with the bclk falling edge
//   s00_axis_tready  out  1   high while the holding register is empty
//   s00_axis_tdata   in   32  {left[15:0], right[15:0]}
//   s00_axis_tlast   in   1   ignored
//   s00_axis_tvalid  in   1   stream word valid
//
// Parameters
//   C_S00_AXIS_TDATA_WIDTH  stream data width; only 32 is supported
//
// Build option
//   I2STX_REPEAT_ON_UNDERRUN_EN
//     defined   : on underrun the last transmitted frame is sent again
//                 (zeros if nothing has been sent since reset)
//     undefined : on underrun a frame of zeros is sent
//
// Data path
//   mclk -> 2-flop synchronizer -> rising-edge detect -> mclk_tick
//   mclk_tick / 2 -> bclk toggle
//   bclk falling toggle -> bit position counter -> lrclk / sdata
//   stream -> holding register -> frame sample registers (at frame wrap)

module i2s_tx_axis #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_areset,
    input  logic                              mclk,
    output logic                              bclk,
    output logic                              lrclk,
    output logic                              sdata,
    output logic                              s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                              s00_axis_tlast,
    input  logic                              s00_axis_tvalid
);

    localparam int DATA_W = 16;   // bits per audio sample
    localparam int POS_W  = 6;    // 64 bit positions per stereo frame

    logic rst;
    assign rst = s00_axis_areset;

    // The stream framing carries no meaning for a continuous audio stream.
    logic unused_tlast;
    assign unused_tlast = s00_axis_tlast;

    // Returns the serial bit for slot position s of a sample. Position 0 is
    // the I2S delay bit after the word select change. Positions 1..16 carry
    // sample bits 15..0. The remaining positions are padding zeros.
    // For s in 1..16 the bit index is 16-s, which equals (0 - s) mod 16.
    function automatic logic slot_bit(input logic signed [DATA_W-1:0] smp,
                                      input logic [4:0]               s);
        logic [3:0] idx;
        idx = 4'd0 - s[3:0];
        if ((s >= 5'd1) && (s <= 5'd16)) begin
            return smp[idx];
        end
        return 1'b0;
    endfunction

    logic                              mclk_p0;
    logic                              mclk_p1;
    logic                              mclk_p2;
    logic                              mclk_tick;
    logic                              tick_div;
    logic [POS_W-1:0]                  pos;
    logic [POS_W-1:0]                  pos_nxt;
    logic                              bclk_fall;
    logic                              frame_load;
    logic                              accept;
    logic [C_S00_AXIS_TDATA_WIDTH-1:0] hold_data;
    logic                              hold_vld;
    logic                              hold_vld_nxt;
    logic signed [DATA_W-1:0]          l_smp;
    logic signed [DATA_W-1:0]          r_smp;
    logic signed [DATA_W-1:0]          cur_smp;

    // ---- stage p0/p1: mclk synchronizer, p2: previous value for edge detect
    always_ff @(posedge s00_axis_aclk) begin
        if (rst) begin
            mclk_p0   <= 1'b0;
            mclk_p1   <= 1'b0;
            mclk_p2   <= 1'b0;
            mclk_tick <= 1'b0;
        end else begin
            mclk_p0   <= mclk;
            mclk_p1   <= mclk_p0;
            mclk_p2   <= mclk_p1;
            mclk_tick <= mclk_p1 & ~mclk_p2;
        end
    end

    // ---- bit clock: every second mclk tick toggles bclk
    always_ff @(posedge s00_axis_aclk) begin
        if (rst) begin
            tick_div <= 1'b0;
            bclk     <= 1'b0;
        end else if (mclk_tick) begin
            tick_div <= ~tick_div;
            if (tick_div) begin
                bclk <= ~bclk;
            end
        end
    end

    // A falling toggle happens on a qualifying tick while bclk is high.
    assign bclk_fall  = mclk_tick & tick_div & bclk;
    assign pos_nxt    = pos + POS_W'(1);
    assign frame_load = bclk_fall & (pos == '1);
    assign accept     = s00_axis_tvalid & s00_axis_tready;

    // The new bit belongs to the position being entered, not the one being
    // left. pos_nxt therefore selects both the channel and the slot bit.
    assign cur_smp = pos_nxt[POS_W-1] ? r_smp : l_smp;

    // ---- serializer: position counter, word select and data, all on the
    //      bclk falling toggle
    always_ff @(posedge s00_axis_aclk) begin
        if (rst) begin
            pos   <= '0;
            lrclk <= 1'b0;
            sdata <= 1'b0;
        end else if (bclk_fall) begin
            pos   <= pos_nxt;
            lrclk <= pos_nxt[POS_W-1];
            sdata <= slot_bit(cur_smp, pos_nxt[4:0]);
        end
    end

    // ---- frame sample registers, reloaded when the position wraps 63 -> 0.
    //      On underrun they either clear or keep the frame just sent.
    always_ff @(posedge s00_axis_aclk) begin
        if (rst) begin
            l_smp <= '0;
            r_smp <= '0;
        end else if (frame_load) begin
            if (hold_vld) begin
                l_smp <= $signed(hold_data[2*DATA_W-1:DATA_W]);
                r_smp <= $signed(hold_data[DATA_W-1:0]);
            end
`ifndef I2STX_REPEAT_ON_UNDERRUN_EN
            else begin
                l_smp <= '0;
                r_smp <= '0;
            end
`endif
        end
    end

    // Holding register occupancy. If a load and an accept land in the same
    // cycle, the load takes the old word, the new word replaces it, and the
    // register stays full.
    always_comb begin
        hold_vld_nxt = hold_vld;
        if (frame_load) begin
            hold_vld_nxt = 1'b0;
        end
        if (accept) begin
            hold_vld_nxt = 1'b1;
        end
    end

    // ---- stream side: holding register and registered tready. tready
    //      depends only on the next holding state, so there is no
    //      combinational path from tvalid to tready.
    always_ff @(posedge s00_axis_aclk) begin
        if (rst) begin
            hold_vld        <= 1'b0;
            s00_axis_tready <= 1'b0;
        end else begin
            hold_vld        <= hold_vld_nxt;
            s00_axis_tready <= ~hold_vld_nxt;
        end
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (rst) begin
            hold_data <= '0;
        end else if (accept) begin
            hold_data <= s00_axis_tdata;
        end
    end

endmodule

// File: tb/tb_i2s_tx_axis.sv
//
// Testbench for i2s_tx_axis. mclk runs at aclk/10. A monitor rebuilds every
// transmitted 64-bit frame from sdata and lrclk, sampled on bclk rising
// edges. It compares each frame against a scoreboard fed by the stream
// handshakes it observes.

module tb_i2s_tx_axis;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        mclk   = 1'b0;
    logic [31:0] tdata  = 32'h0;
    logic        tlast  = 1'b0;
    logic        tvalid = 1'b0;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        tready;

    i2s_tx_axis #(.C_S00_AXIS_TDATA_WIDTH(32)) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .mclk            (mclk),
        .bclk            (bclk),
        .lrclk           (lrclk),
        .sdata           (sdata),
        .s00_axis_tready (tready),
        .s00_axis_tdata  (tdata),
        .s00_axis_tlast  (tlast),
        .s00_axis_tvalid (tvalid)
    );

    always #5 clk = ~clk;
    // mclk edges fall on aclk falling edges, well away from the sampling edge.
    always #50 mclk = ~mclk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int frames_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [31:0] word_q[$];    // words accepted but not yet loaded
    logic [31:0] frame_q[$];   // word expected in each upcoming frame
    logic [31:0] last_word = 32'h0;
    logic        pend_acc  = 1'b0;
    logic [31:0] pend_word = 32'h0;
    logic        rst_seen  = 1'b1;
    logic        bclk_q    = 1'b0;
    logic        lr_q      = 1'b0;
    int          bitn      = 0;
    logic [63:0] got_sd;
    logic [63:0] got_lr;

    // Expected serial pattern of one frame; bit 63 is the first bit sent.
    function automatic logic [63:0] frame_bits(input logic [31:0] w);
        logic [63:0] v;
        logic [15:0] smp;
        int          s;
        v = '0;
        for (int i = 0; i < 64; i++) begin
            s   = i % 32;
            smp = (i < 32) ? w[31:16] : w[15:0];
            if (s >= 1 && s <= 16) v[63 - i] = smp[16 - s];
        end
        return v;
    endfunction

    // Monitor / scoreboard, evaluated on every aclk falling edge
    initial begin : monitor
        logic [31:0] w;
        logic [31:0] exp_w;
        logic [63:0] exp_sd;
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                word_q.delete();
                frame_q.delete();
                frame_q.push_back(32'h0);
                last_word = 32'h0;
                bitn      = 0;
            end else begin
                if (!bclk_q && bclk) begin
                    got_sd[63 - bitn] = sdata;
                    got_lr[63 - bitn] = lrclk;
                    bitn++;
                    if (bitn == 64) begin
                        bitn = 0;
                        n_cmp++;
                        if (frame_q.size() == 0) begin
                            n_err++;
                            $display("FAIL frame_queue: got a frame %h, want none pending", got_sd);
                        end else begin
                            exp_w  = frame_q.pop_front();
                            exp_sd = frame_bits(exp_w);
                            if (got_sd !== exp_sd) begin
                                n_err++;
                                $display("FAIL frame_sdata: got %h, want %h (word %h)", got_sd, exp_sd, exp_w);
                            end
                            n_cmp++;
                            if (got_lr !== {32'h0, 32'hFFFF_FFFF}) begin
                                n_err++;
                                $display("FAIL frame_lrclk: got %h, want %h", got_lr, {32'h0, 32'hFFFF_FFFF});
                            end
                        end
                        frames_done++;
                    end
                end
                // lrclk falling marks the frame wrap, where the next word loads.
                if (lr_q && !lrclk) begin
                    if (word_q.size() > 0) begin
                        w = word_q.pop_front();
                        last_word = w;
                    end else begin
`ifdef I2STX_REPEAT_ON_UNDERRUN_EN
                        w = last_word;
`else
                        w = 32'h0;
`endif
                    end
                    frame_q.push_back(w);
                end
                if (pend_acc) begin
                    word_q.push_back(pend_word);
                    n_cmp++;
                    if (word_q.size() > 1) begin
                        n_err++;
                        $display("FAIL hold_overflow: got %0d words held, want at most 1", word_q.size());
                    end
                end
                n_cmp++;
                if (tready !== (word_q.size() == 0)) begin
                    n_err++;
                    $display("FAIL tready: got %b, want %b at cycle %0d", tready, (word_q.size() == 0), cyc);
                end
            end
            pend_acc  = !rst && tvalid && tready;
            pend_word = tdata;
            bclk_q    = bclk;
            lr_q      = lrclk;
            rst_seen  = rst;
        end
    end

    // Waits for a rising edge of bclk (use_lr=0) or lrclk (use_lr=1).
    task automatic wait_rise(input bit use_lr, input int budget, output int at, output bit ok);
        logic prev;
        logic cur;
        prev = use_lr ? lrclk : bclk;
        ok   = 1'b0;
        at   = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cur = use_lr ? lrclk : bclk;
            if (!prev && cur) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
            prev = cur;
        end
    endtask

    // Offers one word and returns once it has been accepted (or the budget ran out).
    task automatic send_word(input logic [31:0] w, input int budget, output int waited);
        @(posedge clk); #1;
        tdata  = w;
        tvalid = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (tready) break;
            waited++;
            if (waited >= budget) break;
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_frames(input int n, output bit ok);
        int target;
        target = frames_done + n;
        ok = 1'b0;
        for (int i = 0; i < n * 2560 + 2600; i++) begin
            @(negedge clk);
            if (frames_done >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        tvalid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bclk, lrclk, sdata, tready} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_outputs: got bclk/lrclk/sdata/tready=%b, want 0000", {bclk, lrclk, sdata, tready});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (tready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_tready: got %b, want 1", tready);
        end
    endtask

    task automatic test_clocks();
        int a;
        int b;
        bit ok1;
        bit ok2;
        wait_rise(1'b0, 200, a, ok1);
        wait_rise(1'b0, 200, b, ok2);
        n_cmp++;
        if (!(ok1 && ok2) || (b - a) != 40) begin
            n_err++;
            $display("FAIL bclk_period: got %0d cycles (seen %b%b), want 40", b - a, ok1, ok2);
        end
        wait_rise(1'b1, 3000, a, ok1);
        wait_rise(1'b1, 3000, b, ok2);
        n_cmp++;
        if (!(ok1 && ok2) || (b - a) != 2560) begin
            n_err++;
            $display("FAIL lrclk_period: got %0d cycles (seen %b%b), want 2560", b - a, ok1, ok2);
        end
    endtask

    task automatic test_single_word();
        int waited;
        bit ok;
        send_word(32'hAA55_8001, 3000, waited);
        tvalid = 1'b0;
        n_cmp++;
        if (waited >= 3000) begin
            n_err++;
            $display("FAIL single_accept: got no accept in %0d cycles, want accept", waited);
        end
        wait_frames(3, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL single_frames: got timeout, want 3 frames");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [4];
        int waited;
        bit ok;
        words[0] = 32'hAA55_8001;
        words[1] = 32'hA5A5_8001;
        words[2] = 32'hAA55_8001;
        words[3] = 32'hA5A5_8001;
        for (int k = 0; k < 4; k++) begin
            send_word(words[k], 3000, waited);
            n_cmp++;
            if (waited >= 3000) begin
                n_err++;
                $display("FAIL b2b_accept: word %0d got no accept, want accept", k);
            end
            if (k > 0) begin
                n_cmp++;
                if (waited < 1) begin
                    n_err++;
                    $display("FAIL b2b_stall: word %0d waited %0d cycles, want at least 1", k, waited);
                end
            end
            if (k < 3) tdata = words[k + 1];
        end
        tvalid = 1'b0;
        wait_frames(2, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL b2b_frames: got timeout, want 2 frames");
        end
    endtask

    task automatic test_underrun();
        int waited;
        bit ok;
        send_word(32'hAA55_8001, 3000, waited);
        tvalid = 1'b0;
        wait_frames(3, ok);
        n_cmp++;
        if (!ok || waited >= 3000) begin
            n_err++;
            $display("FAIL underrun_frames: got timeout (waited %0d), want 3 frames", waited);
        end
    endtask

    task automatic test_reset_mid_frame();
        int waited;
        bit ok;
        bit hit;
        send_word(32'h7FFF_FFFF, 3000, waited);
        tvalid = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (lrclk && sdata) begin
                hit = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!hit) begin
            n_err++;
            $display("FAIL reset_mid_reach: got no right-slot data bit, want sdata=1 with lrclk=1");
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bclk, lrclk, sdata} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got bclk/lrclk/sdata=%b, want 000", {bclk, lrclk, sdata});
        end
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        send_word(32'h1234_8765, 3000, waited);
        tvalid = 1'b0;
        wait_frames(3, ok);
        n_cmp++;
        if (!ok || waited >= 3000) begin
            n_err++;
            $display("FAIL reset_mid_frames: got timeout (waited %0d), want 3 frames", waited);
        end
    endtask

    initial begin
        test_reset();
        test_clocks();
        test_single_word();
        test_back_to_back();
        test_underrun();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
